// File: rtl/dcr_decode_wb_pipe_if.sv
// Decode-stage pipeline handshake bundle: IF/ID side request and the ID/EXE
// register outputs travelling toward EXE.
interface dcr_decode_wb_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int PCW  = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [PCW-1:0]  pc_plus_one;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rs_val_o;
  logic [XLEN-1:0] rt_val_o;
  logic [XLEN-1:0] imm_o;
  logic [XLEN-1:0] shamt_o;
  logic [XLEN-1:0] pc_plus_one_o;
  logic [AW-1:0]   wr_addr_o;

  modport master (
    output in_valid, instr, pc_plus_one, out_ready,
    input  in_ready, out_valid, rs_val_o, rt_val_o, imm_o, shamt_o,
           pc_plus_one_o, wr_addr_o
  );

  modport slave (
    input  in_valid, instr, pc_plus_one, out_ready,
    output in_ready, out_valid, rs_val_o, rt_val_o, imm_o, shamt_o,
           pc_plus_one_o, wr_addr_o
  );
endinterface

// File: rtl/dcr_decode_wb_pipe.sv
// Decode / write-back stage: register file with write-through, operand
// bypass, signed compare flags and the ID/EXE valid/ready register.
module dcr_decode_wb_pipe #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int PCW  = 8,
  parameter  int NFWD = 3,
  parameter  int CNTW = 16,
  localparam int AW   = $clog2(NREG),
  localparam int SW   = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 flush,
  dcr_decode_wb_pipe_if.slave  pipe,
  input  logic                 sign_ext,
  input  logic                 with_zero,
  input  logic [1:0]           write_dest,
  input  logic                 wb_we,
  input  logic                 wb_mem_read,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      alu_data,
  input  logic [XLEN-1:0]      mem_data,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [SW-1:0]        fwd_rs_sel,
  input  logic [SW-1:0]        fwd_rt_sel,
  output logic [XLEN-1:0]      wb_bypass_o,
  output logic [5:0]           opcode_o,
  output logic [5:0]           funct_o,
  output logic [AW-1:0]        rs_o,
  output logic [AW-1:0]        rt_o,
  output logic [AW-1:0]        wr_addr_pmcu_o,
  output logic [2:0]           gse_o,
  output logic [PCW-1:0]       branch_tgt_o,
  output logic [PCW-1:0]       jump_tgt_o,
  output logic [PCW-1:0]       reg_tgt_o,
  output logic [CNTW-1:0]      stall_cnt_o
);

  function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] v, input logic se);
    ext_imm = se ? {{(XLEN-16){v[15]}}, v} : {{(XLEN-16){1'b0}}, v};
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] wb_data, rd1, rd2, rs_val, rt_val;
  logic [AW-1:0]   rs, rt, rd, dest;
  logic            wb_fire, load;
  logic signed [XLEN-1:0] cmp_a, cmp_b;

  logic            vld_p1;
  logic [XLEN-1:0] rs_val_p1, rt_val_p1, imm_p1, shamt_p1, pc_p1;
  logic [AW-1:0]   wr_addr_p1;
  logic [CNTW-1:0] stall_cnt;

  assign rs = pipe.instr[20+AW:21];
  assign rt = pipe.instr[15+AW:16];
  assign rd = pipe.instr[10+AW:11];

  assign wb_data = wb_mem_read ? mem_data : alu_data;
  assign wb_fire = wb_we && clken && (wb_addr != '0);

  // Same-cycle write-back is visible to the decoding instruction.
  assign rd1 = (rs == '0) ? '0 : (wb_fire && wb_addr == rs) ? wb_data : rf[rs];
  assign rd2 = (rt == '0) ? '0 : (wb_fire && wb_addr == rt) ? wb_data : rf[rt];

  always_comb begin
    rs_val = rd1;
    rt_val = rd2;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_rs_sel == SW'(k)) rs_val = fwd_data[(k-1)*XLEN +: XLEN];
      if (fwd_rt_sel == SW'(k)) rt_val = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  always_comb begin
    case (write_dest)
      2'b01:   dest = rd;
      2'b10:   dest = AW'(NREG - 1);
      default: dest = rt;
    endcase
  end

  assign cmp_a = rs_val;
  assign cmp_b = with_zero ? '0 : rt_val;
  assign gse_o = {cmp_a > cmp_b, cmp_a < cmp_b, cmp_a == cmp_b};

  assign wb_bypass_o    = wb_data;
  assign opcode_o       = pipe.instr[31:26];
  assign funct_o        = pipe.instr[5:0];
  assign rs_o           = rs;
  assign rt_o           = rt;
  assign wr_addr_pmcu_o = dest;
  assign branch_tgt_o   = pipe.instr[PCW-1:0] + pipe.pc_plus_one;
  assign jump_tgt_o     = pipe.instr[PCW-1:0];
  assign reg_tgt_o      = rs_val[PCW-1:0];

  assign pipe.in_ready = !vld_p1 || pipe.out_ready;
  assign load          = clken && pipe.in_valid && pipe.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_fire) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ---- ID/EXE register (p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rs_val_p1  <= '0;
      rt_val_p1  <= '0;
      imm_p1     <= '0;
      shamt_p1   <= '0;
      pc_p1      <= '0;
      wr_addr_p1 <= '0;
    end else if (clken) begin
      if (flush) begin
        vld_p1     <= 1'b0;
        rs_val_p1  <= '0;
        rt_val_p1  <= '0;
        imm_p1     <= '0;
        shamt_p1   <= '0;
        pc_p1      <= '0;
        wr_addr_p1 <= '0;
      end else if (load) begin
        vld_p1     <= 1'b1;
        rs_val_p1  <= rs_val;
        rt_val_p1  <= rt_val;
        imm_p1     <= ext_imm(pipe.instr[15:0], sign_ext);
        shamt_p1   <= XLEN'(pipe.instr[10:6]);
        pc_p1      <= XLEN'(pipe.pc_plus_one);
        wr_addr_p1 <= dest;
      end else if (vld_p1 && pipe.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clken && pipe.in_valid && !pipe.in_ready && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign pipe.out_valid     = vld_p1;
  assign pipe.rs_val_o      = rs_val_p1;
  assign pipe.rt_val_o      = rt_val_p1;
  assign pipe.imm_o         = imm_p1;
  assign pipe.shamt_o       = shamt_p1;
  assign pipe.pc_plus_one_o = pc_p1;
  assign pipe.wr_addr_o     = wr_addr_p1;
  assign stall_cnt_o        = stall_cnt;

endmodule

// File: tb/tb_dcr_decode_wb_pipe.sv
// Directed bench for dcr_decode_wb_pipe with default parameters.
module tb_dcr_decode_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, clken, flush, sign_ext, with_zero, wb_we, wb_mem_read;
  logic [1:0]  write_dest;
  logic [4:0]  wb_addr;
  logic [31:0] alu_data, mem_data, wb_bypass_o;
  logic [95:0] fwd_data;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [5:0]  opcode_o, funct_o;
  logic [4:0]  rs_o, rt_o, wr_addr_pmcu_o;
  logic [2:0]  gse_o;
  logic [7:0]  branch_tgt_o, jump_tgt_o, reg_tgt_o;
  logic [15:0] stall_cnt_o;

  int ntests = 0;
  int nfail  = 0;

  dcr_decode_wb_pipe_if #(.XLEN(32), .AW(5), .PCW(8)) pif ();

  dcr_decode_wb_pipe dut (
    .clk(clk), .rst(rst), .clken(clken), .flush(flush), .pipe(pif),
    .sign_ext(sign_ext), .with_zero(with_zero), .write_dest(write_dest),
    .wb_we(wb_we), .wb_mem_read(wb_mem_read), .wb_addr(wb_addr),
    .alu_data(alu_data), .mem_data(mem_data), .fwd_data(fwd_data),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .wb_bypass_o(wb_bypass_o), .opcode_o(opcode_o), .funct_o(funct_o),
    .rs_o(rs_o), .rt_o(rt_o), .wr_addr_pmcu_o(wr_addr_pmcu_o), .gse_o(gse_o),
    .branch_tgt_o(branch_tgt_o), .jump_tgt_o(jump_tgt_o), .reg_tgt_o(reg_tgt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] s, t, d,
                                     input logic [4:0] sh, input logic [5:0] fn);
    rr = {op, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] s, t,
                                     input logic [15:0] imm);
    ri = {op, s, t, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; flush = 1'b0; sign_ext = 1'b0; with_zero = 1'b0;
    wb_we = 1'b0; wb_mem_read = 1'b0; write_dest = 2'b00; wb_addr = '0;
    alu_data = '0; mem_data = '0; fwd_data = '0; fwd_rs_sel = '0; fwd_rt_sel = '0;
    pif.in_valid = 1'b0; pif.instr = '0; pif.pc_plus_one = '0; pif.out_ready = 1'b1;
    #12 rst = 1'b0;
    chk("rst_out_valid", pif.out_valid, 0);
    chk("rst_rs_val", pif.rs_val_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_in_ready", pif.in_ready, 1);
    tick();

    // write r5 via ALU path, then decode it
    wb_we = 1'b1; wb_addr = 5'd5; alu_data = 32'h0000_00A5; mem_data = 32'hFFFF;
    tick();
    wb_we = 1'b0; pif.instr = rr(6'h00, 5'd5, 5'd0, 5'd9, 5'd0, 6'h00);
    write_dest = 2'b01; pif.in_valid = 1'b1;
    tick();
    chk("r5_rs_val", pif.rs_val_o, 32'hA5);
    chk("r5_out_valid", pif.out_valid, 1);
    chk("r5_wr_addr", pif.wr_addr_o, 9);

    // write-through from the mem path while decoding r7
    wb_we = 1'b1; wb_mem_read = 1'b1; wb_addr = 5'd7;
    mem_data = 32'hDEAD_BEEF; alu_data = 32'h1111;
    pif.instr = rr(6'h00, 5'd7, 5'd7, 5'd0, 5'd0, 6'h00);
    #1 chk("wb_bypass", wb_bypass_o, 32'hDEAD_BEEF);
    tick();
    chk("wt_rs_val", pif.rs_val_o, 32'hDEAD_BEEF);
    chk("wt_rt_val", pif.rt_val_o, 32'hDEAD_BEEF);

    // writes to r0 are dropped
    wb_mem_read = 1'b0; wb_addr = 5'd0; alu_data = 32'h1234_5678;
    pif.instr = rr(6'h00, 5'd0, 5'd7, 5'd0, 5'd0, 6'h00);
    tick();
    chk("r0_rs_val", pif.rs_val_o, 0);
    chk("r0_rt_val", pif.rt_val_o, 32'hDEAD_BEEF);
    wb_we = 1'b0;

    // bypass selection
    fwd_data = {32'h33, 32'h22, 32'h11};
    fwd_rs_sel = 2'd1; fwd_rt_sel = 2'd3;
    pif.instr = rr(6'h00, 5'd5, 5'd7, 5'd0, 5'd0, 6'h00);
    tick();
    chk("fwd_rs1", pif.rs_val_o, 32'h11);
    chk("fwd_rt3", pif.rt_val_o, 32'h33);
    fwd_rs_sel = 2'd3; fwd_rt_sel = 2'd0;
    tick();
    chk("fwd_rs3", pif.rs_val_o, 32'h33);
    chk("fwd_rt_rf", pif.rt_val_o, 32'hDEAD_BEEF);

    // signed compare flags
    fwd_data = {32'h33, 32'h1, 32'hFFFF_FFFF};
    fwd_rs_sel = 2'd1; fwd_rt_sel = 2'd2;
    #1 chk("gse_neg_lt", gse_o, 3'b010);
    with_zero = 1'b1; fwd_data = {32'h33, 32'h1, 32'h5};
    #1 chk("gse_zero_gt", gse_o, 3'b100);
    chk("reg_tgt_fwd", reg_tgt_o, 8'h05);
    with_zero = 1'b0; fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0;

    // immediate extension and fields
    pif.instr = ri(6'h23, 5'd5, 5'd7, 16'h8000); sign_ext = 1'b1;
    #1 chk("opcode", opcode_o, 6'h23);
    chk("rs_field", rs_o, 5);
    chk("rt_field", rt_o, 7);
    tick();
    chk("imm_sext", pif.imm_o, 32'hFFFF_8000);
    sign_ext = 1'b0;
    tick();
    chk("imm_zext", pif.imm_o, 32'h0000_8000);
    pif.instr = rr(6'h00, 5'd5, 5'd7, 5'd3, 5'd17, 6'h2A); write_dest = 2'b10;
    #1 chk("funct", funct_o, 6'h2A);
    chk("dest_link", wr_addr_pmcu_o, 31);
    tick();
    chk("shamt", pif.shamt_o, 17);

    // targets
    pif.instr = ri(6'h04, 5'd5, 5'd7, 16'h0020); pif.pc_plus_one = 8'hF0;
    #1 chk("branch_wrap", branch_tgt_o, 8'h10);
    chk("jump_tgt", jump_tgt_o, 8'h20);
    tick();
    chk("pc_plus_one_o", pif.pc_plus_one_o, 32'hF0);

    // clken low freezes the register
    clken = 1'b0; pif.instr = rr(6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 6'h00);
    tick();
    chk("clken_valid", pif.out_valid, 1);
    chk("clken_hold", pif.rs_val_o, 32'hA5);
    clken = 1'b1;

    // drain, then stall with EXE not ready
    pif.in_valid = 1'b0;
    tick();
    chk("drain_valid", pif.out_valid, 0);
    pif.in_valid = 1'b1; pif.out_ready = 1'b0;
    pif.instr = ri(6'h00, 5'd5, 5'd0, 16'h1234); sign_ext = 1'b0;
    tick();
    chk("stall_load_imm", pif.imm_o, 32'h1234);
    pif.instr = ri(6'h00, 5'd7, 5'd0, 16'h5678);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_cnt4", stall_cnt_o, 4);
    chk("stall_in_ready", pif.in_ready, 0);
    chk("stall_valid", pif.out_valid, 1);
    chk("stall_imm_hold", pif.imm_o, 32'h1234);
    chk("stall_rs_hold", pif.rs_val_o, 32'hA5);
    flush = 1'b1;
    tick();
    flush = 1'b0; pif.in_valid = 1'b0;
    chk("flush_valid", pif.out_valid, 0);
    chk("flush_imm", pif.imm_o, 0);
    chk("flush_rs", pif.rs_val_o, 0);
    chk("flush_stall_cnt", stall_cnt_o, 4);

    // async reset mid-stream
    pif.out_ready = 1'b1; pif.in_valid = 1'b1;
    pif.instr = rr(6'h00, 5'd5, 5'd0, 5'd9, 5'd0, 6'h00); write_dest = 2'b01;
    tick();
    chk("pre_rst_rs", pif.rs_val_o, 32'hA5);
    pif.in_valid = 1'b0;
    #1 chk("pre_rst_rf", reg_tgt_o, 8'hA5);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", pif.out_valid, 0);
    chk("arst_rs", pif.rs_val_o, 0);
    chk("arst_wr_addr", pif.wr_addr_o, 0);
    chk("arst_rf", reg_tgt_o, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dcr_decode_wb_pipe.md
Name: dcr_decode_wb_pipe

Overview:
Parametrised decode/write-back stage for the single-core RISC pipeline. It has a configurable register file with an internal write-through path, N-source operand forwarding and signed compare flags for the PMCU. The ID/EXE register uses a valid/ready handshake with stall and flush, plus a saturating stall counter. It sits between IF/ID and EXE and receives write-back data from the MEM/WB side.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers (power of 2, >=2); AW = clog2(NREG)
PCW, 8, PC / branch / jump target width (<=16)
NFWD, 3, number of bypass sources; SW = clog2(NFWD+1)
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
clken  in  1  global stage enable; gates pipeline register, regfile write and counter
flush  in  1  squash the ID/EXE register contents
in_valid  in  1  instr/pc_plus_one valid
in_ready  out  1  stage can accept
instr  in  32  instruction word
pc_plus_one  in  PCW  PC+1 of instr
sign_ext, with_zero  in  1 each  immediate sign-extend; compare against zero
write_dest  in  2  01=rd, 10=reg NREG-1 (link), else rt
wb_we  in  1  write-back enable
wb_mem_read  in  1  1: write mem_data, 0: write alu_data
wb_addr  in  AW  write-back address
alu_data, mem_data  in  XLEN each  write-back candidates
fwd_data  in  NFWD*XLEN  bypass sources; source k is slice k-1
fwd_rs_sel, fwd_rt_sel  in  SW each  0=regfile, k=source k
out_valid  out  1  ID/EXE register holds valid op
out_ready  in  1  EXE accepts
rs_val_o, rt_val_o, imm_o, shamt_o, pc_plus_one_o  out  XLEN each  registered operands
wr_addr_o  out  AW  registered destination
wb_bypass_o  out  XLEN  selected write-back data (comb)
opcode_o, funct_o  out  6 each  comb instr fields
rs_o, rt_o, wr_addr_pmcu_o  out  AW each  comb
gse_o  out  3  comb {gt,lt,eq}, signed
branch_tgt_o, jump_tgt_o, reg_tgt_o  out  PCW each  comb
stall_cnt_o  out  CNTW  saturating stall count

Behaviour:
- Reset (async): all regfile entries 0, out_valid=0, all registered outputs 0, stall_cnt_o=0.
- Fields: rs=instr[20+AW:21], rt=instr[15+AW:16], rd=instr[10+AW:11], shamt=instr[10:6], imm=instr[15:0]. Register index 0 is hardwired 0; writes to it are ignored.
- Write-back: wb_data = wb_mem_read ? mem_data : alu_data. The regfile is written at posedge when wb_we && clken && wb_addr!=0. Write-back is independent of flush, stall and in_valid.
- Read: comb. If wb_we && clken && wb_addr==read addr && addr!=0, the read returns wb_data (write-through); otherwise it returns the stored value.
- Forwarding: rs_val = fwd_rs_sel==0 || fwd_rs_sel>NFWD ? read1 : fwd_data[sel-1]. rt_val is identical but uses fwd_rt_sel only.
- Compare: y = with_zero ? 0 : rt_val. gse = {rs>y, rs<y, rs==y}, XLEN-bit signed compare.
- imm: sign_ext ? sign-extend 16->XLEN : zero-extend. shamt and pc_plus_one are zero-extended to XLEN.
- Targets: branch_tgt = (instr[PCW-1:0] + pc_plus_one) mod 2^PCW, wraps. jump_tgt = instr[PCW-1:0]. reg_tgt = rs_val[PCW-1:0].
- Handshake: in_ready = !out_valid || out_ready (comb). Load = clken && in_valid && in_ready; it captures all registered outputs with 1-cycle latency and sets out_valid=1.
- If the register is not loaded and out_valid && out_ready, out_valid clears. Data holds while out_valid && !out_ready.
- Flush (with clken): next cycle out_valid=0 and registered data=0. Flush overrides a simultaneous load, and the instruction at the input is dropped.
- clken=0: register, regfile and counter all hold.
- stall_cnt increments when clken && in_valid && !in_ready && !flush, and saturates at 2^CNTW-1.
- Reset mid-operation discards in-flight op immediately (async).

Test Plan:
- Write r5=0x0000_00A5 (wb_we, alu path); next cycle decode rs=5, fwd_rs_sel=0 -> rs_val_o=0xA5 and out_valid=1 one cycle after load.
- Same-cycle wb to r7=0xDEAD_BEEF (mem path) while decoding rs=rt=7 -> rs_val_o=rt_val_o=0xDEADBEEF; write to r0 -> r0 still reads 0.
- fwd_rs_sel=1, fwd_rt_sel=3, sources 0x11/0x22/0x33 -> rs_val_o=0x11, rt_val_o=0x33. Also check fwd_rs_sel=3 with fwd_rt_sel=0 -> rt_val_o is the regfile value.
- rs=-1, rt=1 -> gse_o=3'b010; with_zero, rs=5 -> 3'b100. imm=0x8000 with sign_ext=1 -> 0xFFFF8000, with sign_ext=0 -> 0x00008000. pc_plus_one=0xF0, instr[7:0]=0x20 -> branch_tgt_o=0x10.
- out_ready=0 for 4 cycles with in_valid=1 -> outputs held, in_ready=0, stall_cnt_o=4. A flush in that window -> out_valid=0 and data=0 next cycle.
- Assert rst mid-stream with out_valid=1 -> out_valid=0, registered outputs=0 and the regfile cleared without waiting for a clock edge.
